// File: rtl/rr_arb_pkg.sv
// ============================================================================
// Module : rr_arb_pkg
// Brief  : Shared arbiter helpers: lowest-set-bit isolate and one-hot encode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rr_arb_pkg;

  localparam int c_MAX_W     = 64;
  localparam int c_MAX_IDX_W = 6;

  // Operates on the widest supported vector; callers size-cast in and out.
  function automatic logic [c_MAX_W-1:0] lsb_onehot(input logic [c_MAX_W-1:0] v);
    return v & (~v + c_MAX_W'(1));
  endfunction

  function automatic logic [c_MAX_IDX_W-1:0] onehot_enc(input logic [c_MAX_W-1:0] oh);
    logic [c_MAX_IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < c_MAX_W; i++) begin
      if (oh[i]) r = r | c_MAX_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_maske.sv
// ============================================================================
// Module : maske
// Brief  : Thermometer mask relative to a pointer (exclusive/inclusive, left/right).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module maske #(
  parameter int W              = 8,
  parameter int P_INCLUSIVE    = 0,
  parameter int LEFT_NOT_RIGHT = 1,
  localparam int IDX_W         = $clog2(W)
) (
  input  logic [IDX_W-1:0] i_ptr,
  output logic [W-1:0]     o_mask
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    if (LEFT_NOT_RIGHT != 0) begin : g_left
      if (P_INCLUSIVE != 0) begin : g_incl
        assign o_mask[i] = (IDX_W'(i) >= i_ptr);
      end else begin : g_excl
        assign o_mask[i] = (IDX_W'(i) > i_ptr);
      end
    end else begin : g_right
      if (P_INCLUSIVE != 0) begin : g_incl
        assign o_mask[i] = (IDX_W'(i) <= i_ptr);
      end else begin : g_excl
        assign o_mask[i] = (IDX_W'(i) < i_ptr);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb.sv
// ============================================================================
// Module : rr_arb
// Brief  : Round-robin arbiter with registered grant held until acknowledged.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb
  import rr_arb_pkg::*;
#(
  parameter int W      = 8,
  localparam int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     req_i,
  input  logic             ack_i,
  output logic [W-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_enc_o,
  output logic             gnt_vld_o
);

  logic [IDX_W-1:0] r_ptr;
  logic [W-1:0]     r_gnt;
  logic [IDX_W-1:0] r_gnt_enc;
  logic             r_vld;

  logic [W-1:0]     w_mask;
  logic [W-1:0]     w_req_eff;
  logic [W-1:0]     w_hi;
  logic [W-1:0]     w_cand;
  logic [W-1:0]     w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_arb_en;

  maske #(
    .W              (W),
    .P_INCLUSIVE    (0),
    .LEFT_NOT_RIGHT (1)
  ) u_maske (
    .i_ptr  (r_ptr),
    .o_mask (w_mask)
  );

  // The requester being acked this cycle must not win again immediately.
  assign w_req_eff = (r_vld && ack_i) ? (req_i & ~r_gnt) : req_i;
  assign w_hi      = w_req_eff & w_mask;
  assign w_cand    = (|w_hi) ? w_hi : w_req_eff;
  assign w_win_oh  = W'(lsb_onehot(c_MAX_W'(w_cand)));
  assign w_win_idx = IDX_W'(onehot_enc(c_MAX_W'(w_win_oh)));
  assign w_arb_en  = !r_vld || ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= IDX_W'(W - 1);
      r_gnt     <= '0;
      r_gnt_enc <= '0;
      r_vld     <= 1'b0;
    end else if (w_arb_en) begin
      if (|w_req_eff) begin
        r_vld     <= 1'b1;
        r_gnt     <= w_win_oh;
        r_gnt_enc <= w_win_idx;
        r_ptr     <= w_win_idx;
      end else begin
        r_vld     <= 1'b0;
        r_gnt     <= '0;
        r_gnt_enc <= '0;
      end
    end
  end

  assign gnt_o     = r_gnt;
  assign gnt_enc_o = r_gnt_enc;
  assign gnt_vld_o = r_vld;

  a_onehot : assert property (@(posedge clk) disable iff (rst)
    gnt_vld_o ? $onehot(gnt_o) : (gnt_o == '0));

  a_enc : assert property (@(posedge clk) disable iff (rst)
    !gnt_vld_o || (gnt_o == (W'(1) << gnt_enc_o)));

  a_hold : assert property (@(posedge clk) disable iff (rst)
    (gnt_vld_o && !ack_i) |=> $stable(gnt_o));

endmodule

`default_nettype wire
